// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer for the RV32IC core.
//
// Executes the decoded system-instruction strobes (ecall, ebreak, mret and the
// CSR read/modify/write forms), holds the M-mode CSRs, takes level-sensitive
// external and timer interrupts, and drives a one-cycle PC redirect to fetch
// on trap entry and on mret.
//
// Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_valid, pc     instruction at the execute point and its PC
//   ecall/ebreak/mret   decoded strobes, qualified by instr_valid
//   csr_write/set/clear/imm, csr_addr, rs1_data, zimm   CSR op controls/operands
//   irq_ext, irq_timer  level interrupt requests
//   csr_rdata           pre-write CSR value for rd (combinational)
//   redirect_valid/pc   fetch redirect, valid for one cycle
//   busy                high in TRAP/RET, pipeline holds and flushes
//   retire              instruction at execute point retired this cycle
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        csr_write,
    input  logic        csr_set,
    input  logic        csr_clear,
    input  logic        csr_imm,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        retire
);

    typedef enum logic [1:0] {StIdle, StTrap, StRet} state_e;

    state_e      state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q, mpie_q;      // mstatus.MIE / mstatus.MPIE
    logic        meie_q, mtie_q;     // mie.MEIE / mie.MTIE
    logic [31:0] mtvec_q;            // bit1 held at 0
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;             // bit0 held at 0
    logic [31:0] mcause_q;

    logic        accept;
    logic        irq_ext_en, irq_tmr_en;
    logic        irq_take, exc_take, mret_take, csr_we;
    logic [31:0] trap_cause, trap_target;
    logic [31:0] csr_src, csr_wdata;

    // Decode what happens to the instruction at the execute point.
    always_comb begin
        accept     = (state_q == StIdle) && instr_valid && !rst;
        irq_ext_en = irq_ext && meie_q;
        irq_tmr_en = irq_timer && mtie_q;
        irq_take   = accept && mie_q && (irq_ext_en || irq_tmr_en);
        exc_take   = accept && !irq_take && (ecall || ebreak);
        mret_take  = accept && !irq_take && !ecall && !ebreak && mret;
        csr_we     = accept && !irq_take && !ecall && !ebreak && !mret && csr_write;
        retire     = accept && !irq_take && !ecall && !ebreak;

        if (irq_take) begin
            trap_cause = irq_ext_en ? 32'h8000_000B : 32'h8000_0007;
        end else if (ecall) begin
            trap_cause = 32'd11;
        end else begin
            trap_cause = 32'd3;
        end

        // Vectored mode offsets only interrupts, by 4 * cause code.
        trap_target = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && irq_take) begin
            trap_target = trap_target + {26'b0, trap_cause[3:0], 2'b00};
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
`endif

    // Pre-write read mux.
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h304: csr_rdata = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h344: csr_rdata = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};
`ifdef CSR_COUNTERS_EN
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            12'hB02: csr_rdata = minstret_q[31:0];
            12'hB82: csr_rdata = minstret_q[63:32];
`endif
            default: csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        csr_src = csr_imm ? {27'b0, zimm} : rs1_data;
        if (csr_set) begin
            csr_wdata = csr_rdata | csr_src;
        end else if (csr_clear) begin
            csr_wdata = csr_rdata & ~csr_src;
        end else begin
            csr_wdata = csr_src;
        end
    end

    assign busy           = (state_q != StIdle);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            mie_q            <= 1'b0;
            mpie_q           <= 1'b0;
            meie_q           <= 1'b0;
            mtie_q           <= 1'b0;
            mtvec_q          <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
            mscratch_q       <= 32'h0;
            mepc_q           <= 32'h0;
            mcause_q         <= 32'h0;
        end else begin
            // TRAP and RET each last exactly one cycle.
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
            if (irq_take || exc_take) begin
                state_q          <= StTrap;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= trap_target;
                mepc_q           <= {pc[31:1], 1'b0};
                mcause_q         <= trap_cause;
                mpie_q           <= mie_q;
                mie_q            <= 1'b0;
            end else if (mret_take) begin
                state_q          <= StRet;
                redirect_valid_q <= 1'b1;
                redirect_pc_q    <= mepc_q;
                mie_q            <= mpie_q;
                mpie_q           <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        mie_q  <= csr_wdata[3];
                        mpie_q <= csr_wdata[7];
                    end
                    12'h304: begin
                        mtie_q <= csr_wdata[7];
                        meie_q <= csr_wdata[11];
                    end
                    12'h305: mtvec_q    <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
                    12'h340: mscratch_q <= csr_wdata;
                    12'h341: mepc_q     <= {csr_wdata[31:1], 1'b0};
                    12'h342: mcause_q   <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_inc, minstret_inc;

    always_comb begin
        mcycle_inc   = mcycle_q + 64'd1;
        minstret_inc = minstret_q + {63'b0, retire};
    end

    // A software write replaces only the written half; the other half still
    // takes this cycle's increment (including any carry).
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mcycle_q[31:0]    <= (csr_we && csr_addr == 12'hB00) ? csr_wdata : mcycle_inc[31:0];
            mcycle_q[63:32]   <= (csr_we && csr_addr == 12'hB80) ? csr_wdata : mcycle_inc[63:32];
            minstret_q[31:0]  <= (csr_we && csr_addr == 12'hB02) ? csr_wdata
                                                                  : minstret_inc[31:0];
            minstret_q[63:32] <= (csr_we && csr_addr == 12'hB82) ? csr_wdata
                                                                  : minstret_inc[63:32];
        end
    end
`endif

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap sequencer for the RV32IC core. Consumes the decoded system-instruction strobes from the control unit (ECall, EBreak, MRET, CSRWrite, CSRSet, CSRClear, CSRI) and executes them. Holds the M-mode CSRs, takes external and timer interrupts, and drives a one-cycle PC redirect to the fetch stage on trap entry and on MRET.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec

- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  an instruction is at the execute point this cycle
- pc  in  32  PC of that instruction
- ecall, ebreak, mret  in  1 each  decoded strobes, qualified by instr_valid
- csr_write, csr_set, csr_clear, csr_imm  in  1 each  CSR op strobes; csr_write marks any CSR instruction
- csr_addr  in  12  instr[31:20]
- rs1_data  in  32  CSR source operand, register form
- zimm  in  5  instr[19:15], immediate form
- irq_ext, irq_timer  in  1  level-sensitive interrupt requests
- csr_rdata  out  32  old CSR value for rd writeback, combinational
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  32  trap vector or mepc
- busy  out  1  high in TRAP/RET; pipeline must hold and flush
- retire  out  1  instruction at execute point retired this cycle

## Operation
- CSR map: mstatus 0x300 (MIE b3, MPIE b7 writable; MPP b12:11 read 2'b11); mie 0x304 (MTIE b7, MEIE b11); mtvec 0x305 (bit1 reads 0, bit0 = vectored mode); mscratch 0x340; mepc 0x341 (bit0 reads 0); mcause 0x342; mip 0x344 read-only (MTIP b7 = irq_timer, MEIP b11 = irq_ext); mhartid 0xF14 reads 0. Unmapped addresses read 0, writes ignored; no illegal-instruction trap.
- Source: src = csr_imm ? {27'b0,zimm} : rs1_data. New value: csr_set ? old|src : csr_clear ? old&~src : src. Writes to read-only bits are ignored.
- csr_rdata = current value at csr_addr, pre-write.
- FSM: IDLE, TRAP, RET. Accepts instructions only in IDLE.
- Priority in IDLE when instr_valid: interrupt > ecall/ebreak > mret > CSR op. Interrupt pending = MIE & ((irq_ext&MEIE)|(irq_timer&MTIE)). External beats timer.
- Trap entry (edge ending cycle N): mepc<=pc; mcause<= 0x8000000B (ext), 0x80000007 (timer), 11 (ecall), 3 (ebreak); MPIE<=MIE; MIE<=0; state<=TRAP. An interrupted instruction is not executed: CSR write suppressed, retire=0.
- MRET: MIE<=MPIE; MPIE<=1; state<=RET.
- retire=1 for accepted instructions other than interrupted, ecall, ebreak.

## Timing
- Reset: all CSRs 0 except mtvec=MTVEC_RESET; state IDLE; redirect_valid=0, busy=0, retire=0. Reset mid-TRAP/RET returns to IDLE next cycle with no redirect.
- CSR write visible to a read in cycle N+1.
- Trap accepted cycle N -> cycle N+1: state TRAP, busy=1, redirect_valid=1, redirect_pc = mtvec[31:2]<<2, plus 4*cause[3:0] for interrupts when mtvec[0]=1. Cycle N+2: IDLE.
- MRET cycle N -> cycle N+1: RET, busy=1, redirect_valid=1, redirect_pc=mepc (value written in cycle N takes effect). Cycle N+2: IDLE.
- instr_valid ignored in TRAP/RET; interrupts arriving then are sampled in the next IDLE cycle.
- Interrupts never taken while MIE=0; a CSR write setting MIE takes effect from cycle N+1.

## Configuration
- CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00 low, 0xB80 high) increments every cycle out of reset; minstret (0xB02/0xB82) increments when retire=1. Software write in a cycle overrides that cycle's increment for the written half; wrap at 2^64 to 0.
- Not defined: these addresses read 0, writes ignored, no counter flops.

## Test plan
- Reset, read 0x300 -> 0x00001800; read 0x305 -> MTVEC_RESET; redirect_valid=0.
- csrrw 0x340 src 0xDEADBEEF then csrrs src 0x10 then csrrci zimm 0x0F -> rdata 0, then 0xDEADBEEF, then 0xDEADBEFF; final mscratch 0xDEADBEF0.
- mtvec=0x100, ecall at pc 0x40 -> next cycle redirect_pc 0x100; mepc 0x40, mcause 11, MIE 0; MRET -> redirect_pc 0x40, MIE restored.
- MIE=1, MEIE=MTIE=1, mtvec=0x201, irq_ext and irq_timer high with csrrw pending -> mcause 0x8000000B, redirect_pc 0x22C, CSR unchanged, retire=0.
- Reset asserted during TRAP -> IDLE next cycle, redirect_valid 0, mstatus 0x1800.
- With CSR_COUNTERS_EN: write mcycle low 0xFFFFFFFF, high 0 -> two cycles later reads high 1, low 0; without macro read 0xB00 -> 0.
